// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR MAC sequencer: ALU opcodes, FSM states
// and the accumulator width rule.
package fir_pkg;

    localparam logic [1:0] SEL_ADD  = 2'b00;
    localparam logic [1:0] SEL_MUL  = 2'b01;
    // Add of two zero operands: keeps the ALU quiet between filter outputs.
    localparam logic [1:0] SEL_IDLE = 2'b00;

    localparam int N_TAPS_DEF  = 16;
    localparam int DW_DEF      = 16;
    localparam int ALU_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int acc_width(input int n_taps, input int dw);
        return 2 * dw + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Sample delay line (circular buffer) and coefficient register file, with
// combinational reads of x[(wr_ptr - k) mod N] and coef[k].
module fir_tap_store
    import fir_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          smp_we,
    input  logic [$clog2(N_TAPS)-1:0]     wr_ptr,
    input  logic signed [DW-1:0]          smp_data,
    input  logic                          coef_we,
    input  logic [$clog2(N_TAPS)-1:0]     coef_addr,
    input  logic signed [DW-1:0]          coef_data,
    input  logic [$clog2(N_TAPS)-1:0]     tap_k,
    output logic signed [DW-1:0]          x_rd,
    output logic signed [DW-1:0]          coef_rd
);

    localparam int AW = $clog2(N_TAPS);

    logic signed [DW-1:0] x_mem    [N_TAPS];
    logic signed [DW-1:0] coef_mem [N_TAPS];
    logic [AW-1:0]        rd_idx;

    // N_TAPS is a power of two, so the pointer difference wraps naturally.
    assign rd_idx  = wr_ptr - tap_k;
    assign x_rd    = x_mem[rd_idx];
    assign coef_rd = coef_mem[tap_k];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_mem[i]    <= '0;
                coef_mem[i] <= '0;
            end
        end else begin
            if (smp_we)
                x_mem[wr_ptr] <= smp_data;
            if (coef_we)
                coef_mem[coef_addr] <= coef_data;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexes an external ALU to produce one FIR output per accepted sample:
// issues one multiply per tap, accumulates returned products, hands off the sum.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int DW      = DW_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int ACC_W   = 36
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic signed [DW-1:0]          s_data,
    output logic                          s_ready,
    input  logic                          cfg_we,
    input  logic [$clog2(N_TAPS)-1:0]     cfg_addr,
    input  logic signed [DW-1:0]          cfg_data,
    output logic                          cfg_ready,
    output logic signed [DW-1:0]          alu_a,
    output logic signed [DW-1:0]          alu_b,
    output logic [1:0]                    alu_select,
    input  logic [31:0]                   alu_result,
    output logic                          m_valid,
    output logic signed [ACC_W-1:0]       m_data,
    input  logic                          m_ready
);

    localparam int AW = $clog2(N_TAPS);

    state_t               state_q, state_d;
    logic [AW-1:0]        k_q;
    logic [AW-1:0]        wr_ptr_q;
    logic [ALU_LAT-1:0]   vld_p0;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [DW-1:0] x_rd, coef_rd;
    logic                 accept, issue, last_tap, tag_out, pipe_empty;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic [31:0] p);
        return {{(ACC_W-32){p[31]}}, p};
    endfunction

    assign accept     = (state_q == IDLE) && s_valid;
    assign issue      = (state_q == MAC);
    assign last_tap   = (k_q == AW'(N_TAPS - 1));
    assign tag_out    = vld_p0[ALU_LAT-1];
    assign pipe_empty = (vld_p0 == '0);

    assign s_ready    = (state_q == IDLE);
    assign cfg_ready  = (state_q == IDLE);
    assign alu_a      = issue ? x_rd : '0;
    assign alu_b      = issue ? coef_rd : '0;
    assign alu_select = issue ? SEL_MUL : SEL_IDLE;

    fir_tap_store #(
        .N_TAPS (N_TAPS),
        .DW     (DW)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .smp_we    (accept),
        .wr_ptr    (wr_ptr_q),
        .smp_data  (s_data),
        .coef_we   (cfg_we && (state_q == IDLE)),
        .coef_addr (cfg_addr),
        .coef_data (cfg_data),
        .tap_k     (k_q),
        .x_rd      (x_rd),
        .coef_rd   (coef_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = MAC;
            MAC:     if (last_tap) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = OUT;
            OUT:     if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                k_q <= '0;
            else if (issue)
                k_q <= k_q + 1'b1;
            if (issue && last_tap)
                wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Stage p0: product-valid tags travel alongside the ALU latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld_p0 <= '0;
        else
            vld_p0 <= ALU_LAT'({vld_p0, issue});
    end

    // Stage p1: accumulate each product as its tag leaves the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_p1 <= '0;
        else if (accept)
            acc_p1 <= '0;
        else if (tag_out)
            acc_p1 <= acc_p1 + sext_prod(alu_result);
    end

    // Stage p2: output register held until the sink takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if ((state_q == DRAIN) && pipe_empty) begin
            m_valid <= 1'b1;
            m_data  <= acc_p1;
        end else if ((state_q == OUT) && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised bench for fir_mac_sequencer with a behavioural ALU and a
// direct-sum FIR reference model.
module tb_fir_mac_sequencer;

    localparam int N   = 16;
    localparam int LAT = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               s_valid = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_ready;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_addr = '0;
    logic signed [15:0] cfg_data = '0;
    logic               cfg_ready;
    logic signed [15:0] alu_a, alu_b;
    logic [1:0]         alu_select;
    logic [31:0]        alu_result = '0;
    logic               m_valid;
    logic signed [35:0] m_data;
    logic               m_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    longint coef_m [N];
    longint hist_m [N];

    fir_mac_sequencer #(
        .N_TAPS (N),
        .DW     (16),
        .ALU_LAT(LAT),
        .ACC_W  (36)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: one register stage, multiply or add by opcode.
    logic [31:0] a32, b32;
    assign a32 = {{16{alu_a[15]}}, alu_a};
    assign b32 = {{16{alu_b[15]}}, alu_b};
    always @(posedge clk)
        alu_result <= (alu_select == 2'b01) ? a32 * b32 : a32 + b32;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < N; k++)
            s += coef_m[k] * hist_m[k];
        return s;
    endfunction

    task automatic model_push(input longint x);
        for (int k = N - 1; k > 0; k--)
            hist_m[k] = hist_m[k-1];
        hist_m[0] = x;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            hist_m[k] = 0;
            coef_m[k] = 0;
        end
    endtask

    task automatic cfg_write(input int addr, input longint val);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = 16'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        coef_m[addr] = longint'(cfg_data);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!s_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("s_ready_wait", longint'(s_ready), 1);
    endtask

    // Feed one sample, check latency and result, optionally stall the sink.
    task automatic send(input longint x, input int bp, input bit cfg_mac,
                        input bit cfg_acc, output longint y_got);
        int lat = 0;
        longint held;
        wait_ready();
        s_valid = 1'b1;
        s_data  = 16'(x);
        if (cfg_acc) begin
            cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 16'sd100;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        if (cfg_acc) coef_m[3] = 100;
        model_push(longint'(s_data));
        while (!m_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            cfg_we = 1'b0;
            if (cfg_mac && lat == 3) begin
                check("cfg_ready_mac", longint'(cfg_ready), 0);
                cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 16'sd100;
            end
        end
        cfg_we = 1'b0;
        check("latency", lat, N + LAT + 1);
        y_got = longint'(m_data);
        check("y", y_got, model_y());
        held = y_got;
        for (int i = 0; i < bp; i++) begin
            s_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_m_data", longint'(m_data), held);
            check("bp_m_valid", longint'(m_valid), 1);
            check("bp_s_ready", longint'(s_ready), 0);
            check("bp_cfg_ready", longint'(cfg_ready), 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("m_valid_drop", longint'(m_valid), 0);
    endtask

    initial begin
        longint y;
        logic signed [15:0] r;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_m_data", longint'(m_data), 0);
        check("rst_alu_sel", longint'(alu_select), 0);
        check("rst_alu_a", longint'(alu_a), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rel_s_ready", longint'(s_ready), 1);
        check("rel_cfg_ready", longint'(cfg_ready), 1);

        // Impulse response with coef[k] = k+1, one long stall on output 3.
        for (int k = 0; k < N; k++) cfg_write(k, k + 1);
        for (int i = 0; i < N; i++) begin
            send((i == 0) ? 1 : 0, (i == 2) ? 10 : 0, 1'b0, 1'b0, y);
            check("impulse", y, i + 1);
        end

        // Extreme values: full-scale negatives everywhere.
        for (int k = 0; k < N; k++) cfg_write(k, -32768);
        for (int i = 0; i < N; i++) begin
            send(-32768, 0, 1'b0, 1'b0, y);
            if (i == N - 1) check("extreme", y, 64'sd17179869184);
        end

        // Coefficient write during MAC is dropped; at accept it is used.
        for (int k = 0; k < N; k++) cfg_write(k, 16'($urandom));
        send(longint'(16'sd1234), 0, 1'b1, 1'b0, y);
        send(longint'(-16'sd777), 0, 1'b0, 1'b0, y);
        send(longint'(16'sd321), 0, 1'b0, 1'b1, y);

        // Reset in the middle of MAC.
        wait_ready();
        s_valid = 1'b1; s_data = 16'sd999;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_m_valid", longint'(m_valid), 0);
        check("midrst_m_data", longint'(m_data), 0);
        check("midrst_alu_sel", longint'(alu_select), 0);
        check("midrst_alu_a", longint'(alu_a), 0);
        check("midrst_alu_b", longint'(alu_b), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_hold", longint'(m_valid), 0);
        end
        @(negedge clk); rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        cfg_write(0, 2);
        send(5, 0, 1'b0, 1'b0, y);
        check("post_rst", y, 10);

        // Random coefficients and 64 random samples; pointer wraps 4 times.
        for (int k = 0; k < N; k++) begin
            r = 16'($urandom);
            cfg_write(k, longint'(r));
        end
        for (int i = 0; i < 64; i++) begin
            r = 16'($urandom);
            send(longint'(r), int'($urandom_range(0, 2)), 1'b0, 1'b0, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller that time-multiplexes the shared 16x16 ALU to compute one FIR output per accepted input sample.
- Owns the sample delay line (circular buffer) and the coefficient register file.
- Issues one multiply per tap to the ALU and accumulates the returned products internally.
- Sits between the sample source and the output sink, wrapping an `alu` instance that lives outside this block.

Parameters:
- N_TAPS, 16, number of filter taps; power of two, 2..64.
- DW, 16, sample and coefficient width; signed two's complement.
- ALU_LAT, 1, cycles from ALU operand presentation to a valid `result`.
- ACC_W, 36, accumulator and output width; must be at least 2*DW + clog2(N_TAPS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- s_valid  in  1  input sample valid.
- s_data  in  DW  signed input sample.
- s_ready  out  1  sequencer can accept a sample.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  clog2(N_TAPS)  coefficient index k.
- cfg_data  in  DW  signed coefficient value.
- cfg_ready  out  1  coefficient writes are accepted this cycle.
- alu_a  out  DW  ALU operand a (sample).
- alu_b  out  DW  ALU operand b (coefficient).
- alu_select  out  2  ALU opcode.
- alu_result  in  32  ALU result, valid ALU_LAT cycles after its operands.
- m_valid  out  1  output sample valid.
- m_data  out  ACC_W  signed FIR output y[n] = sum over k of c[k]*x[n-k].
- m_ready  in  1  sink accepts the output.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; delay line, coefficients, write pointer, accumulator and tap counter all clear to 0.
  - The product-valid tag pipeline is flushed.
  - alu_a=0, alu_b=0, alu_select=SEL_IDLE, m_valid=0, m_data=0.
  - s_ready=1 and cfg_ready=1 on the first cycle after release.
- States: IDLE, MAC, DRAIN, OUT.
- IDLE:
  - s_ready=1 and cfg_ready=1.
  - On s_valid & s_ready: write s_data at wr_ptr, clear the accumulator, set tap k=0, go to MAC.
  - cfg_we in IDLE writes coef[cfg_addr]=cfg_data.
  - If cfg_we and a sample accept happen on the same edge, the coefficient write takes effect before the MAC starts.
- MAC (exactly N_TAPS cycles):
  - Each cycle: alu_a = x[(wr_ptr - k) mod N_TAPS], alu_b = coef[k], alu_select = SEL_MUL, and a valid tag enters the ALU_LAT-deep tag pipe; then k++.
  - When k=N_TAPS-1 has been issued, advance wr_ptr (wrapping mod N_TAPS) and go to DRAIN.
- Accumulate:
  - When a tag exits the pipe: acc += sign-extended alu_result, where alu_result is a 32-bit signed product.
  - Wrap-around in ACC_W bits; ACC_W sizing guarantees no overflow.
- DRAIN:
  - alu_select=SEL_IDLE.
  - Once the last tag has been accumulated, latch m_data=acc, set m_valid=1, go to OUT.
- OUT:
  - Hold m_data and m_valid until m_ready.
  - On m_valid & m_ready: drop m_valid and go to IDLE. A new sample can be accepted on the next cycle.
- Latency:
  - m_valid rises exactly N_TAPS + ALU_LAT + 1 cycles after the sample-accepting edge.
  - With m_ready held high, throughput is one sample per N_TAPS + ALU_LAT + 3 cycles.
- Outside IDLE: s_ready=0 and cfg_ready=0. cfg_we outside IDLE is ignored and coefficients are unchanged.
- Reset mid-operation:
  - Aborts immediately; in-flight products are discarded and no m_valid is produced.
  - The delay line is cleared, so the next output is computed over zero history.
- Initial history: before N_TAPS samples have been accepted, missing history taps read 0.
- m_ready asserted while m_valid=0 has no effect.

Decomposition:
- Package fir_pkg:
  - ALU opcode constants SEL_ADD=2'b00, SEL_MUL=2'b01, SEL_IDLE=2'b00 (add of zero operands; harmless).
  - State enum {IDLE, MAC, DRAIN, OUT}.
  - Default N_TAPS, DW, ALU_LAT.
  - Function acc_width(N_TAPS, DW).
- One sub-module: fir_tap_store.
  - Contains the delay-line circular buffer and the coefficient register file.
  - Write/read ports: sample write at wr_ptr, coefficient write, combinational read of x[(wr_ptr-k) mod N] and coef[k].
- FSM, tag pipe and accumulator stay in fir_mac_sequencer.

Test Plan:
- Impulse response:
  - Stimulus: coef[k]=k+1; feed sample 1 followed by 15 zeros.
  - Required: outputs 1, 2, ..., 16 in order.
  - Each m_valid rises exactly 18 cycles after its accept edge (N=16, ALU_LAT=1).
- Extreme values:
  - Stimulus: all coef = -32768; 16 samples of -32768.
  - Required: 16th output = 16 * 2^30 = 17179869184, fits in ACC_W=36 with no wrap.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid.
  - Required: m_data stable, s_ready=0 and cfg_ready=0 throughout; accept occurs only after the handshake.
- Coefficient write blocking:
  - Stimulus: cfg_we with addr 3, data 100 during MAC.
  - Required: ignored; coef[3] is unchanged on the next output.
  - Stimulus: the same write in IDLE, on the same edge as a sample accept.
  - Required: the new value is used for that output.
- Reset mid-MAC:
  - Stimulus: assert rst=0 at tap 7.
  - Required: m_valid stays 0, all outputs go to 0 asynchronously.
  - Required: after release and one sample of 5 with coef[0]=2, the output is 10.
- Reference comparison:
  - Stimulus: 64 samples from input.txt with coefficients.txt loaded.
  - Required: m_data matches the golden FIR output for every sample, with wr_ptr wrapping 4 times.
